// File: rtl/init_reset_sequencer.sv
// Fabric reset sequencer: waits for device init + bank calibration, qualifies PLL lock,
// holds reset for a fixed count, then releases; re-arms on lock/init/external reset loss.

module init_reset_sequencer_sync #(
    parameter logic RST_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);
    logic meta;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta <= RST_VAL;
            q    <= RST_VAL;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end
endmodule

module init_reset_sequencer #(
    parameter int unsigned HOLD_CYCLES = 16,
    parameter int unsigned LOCK_FILTER = 4,
    parameter logic [3:0]  CALIB_MASK  = 4'b1111
) (
    input  logic       CLK,
    input  logic       RESETN,
    input  logic       EXT_RST_N,
    input  logic       DEVICE_INIT_DONE,
    input  logic [3:0] CALIB_STATUS,
    input  logic       PLL_LOCK,
    output logic       FABRIC_RESET_N,
    output logic       CALIB_DONE,
    output logic [1:0] SEQ_STATE,
    output logic [7:0] LOCK_LOST_CNT
);
    localparam int NSYNC = 7;
    // Only the external reset request idles high so a fresh reset does not look like a request.
    localparam logic [NSYNC-1:0] SYNC_RST = 7'b100_0000;

    typedef enum logic [1:0] {
        WAIT_INIT = 2'd0,
        WAIT_LOCK = 2'd1,
        HOLD      = 2'd2,
        RUN       = 2'd3
    } seq_state_t;

    logic [NSYNC-1:0] async_in;
    logic [NSYNC-1:0] sync_out;
    logic             ext_rst_n_s;
    logic             init_done_s;
    logic [3:0]       calib_s;
    logic             pll_lock_s;
    logic             calib_ok;
    logic             init_ok;

    seq_state_t  state;
    seq_state_t  state_nxt;
    logic [15:0] cnt;
    logic [15:0] cnt_nxt;
    logic        cnt_inc;
    logic        lock_lost;

    assign async_in = {EXT_RST_N, DEVICE_INIT_DONE, CALIB_STATUS, PLL_LOCK};

    for (genvar i = 0; i < NSYNC; i++) begin : g_sync
        init_reset_sequencer_sync #(.RST_VAL(SYNC_RST[i])) u_sync (
            .clk   (CLK),
            .rst_n (RESETN),
            .d     (async_in[i]),
            .q     (sync_out[i])
        );
    end

    assign {ext_rst_n_s, init_done_s, calib_s, pll_lock_s} = sync_out;

    assign calib_ok = &(calib_s | ~CALIB_MASK);
    assign init_ok  = init_done_s & calib_ok;

    always_comb begin
        state_nxt = state;
        cnt_inc   = 1'b0;
        if (!ext_rst_n_s || !init_ok) begin
            state_nxt = WAIT_INIT;
        end else begin
            case (state)
                WAIT_INIT: state_nxt = WAIT_LOCK;
                WAIT_LOCK: begin
                    if (pll_lock_s) begin
                        if (cnt == 16'(LOCK_FILTER - 1)) state_nxt = HOLD;
                        else                             cnt_inc   = 1'b1;
                    end
                end
                HOLD: begin
                    if (!pll_lock_s)                      state_nxt = WAIT_LOCK;
                    else if (cnt == 16'(HOLD_CYCLES - 1)) state_nxt = RUN;
                    else                                  cnt_inc   = 1'b1;
                end
                RUN: if (!pll_lock_s) state_nxt = WAIT_LOCK;
                default: state_nxt = WAIT_INIT;
            endcase
        end
    end

    // Counting only ever happens while staying put, so anything else (state change,
    // lock dropped in WAIT_LOCK, idle states) clears the shared counter.
    assign cnt_nxt   = cnt_inc ? cnt + 16'd1 : 16'd0;
    assign lock_lost = (state == RUN) && (state_nxt == WAIT_LOCK);

    always_ff @(posedge CLK or negedge RESETN) begin
        if (!RESETN) begin
            state          <= WAIT_INIT;
            cnt            <= 16'd0;
            FABRIC_RESET_N <= 1'b0;
            CALIB_DONE     <= 1'b0;
            LOCK_LOST_CNT  <= 8'd0;
        end else begin
            state          <= state_nxt;
            cnt            <= cnt_nxt;
            FABRIC_RESET_N <= (state_nxt == RUN);
            CALIB_DONE     <= calib_ok;
            if (lock_lost && (LOCK_LOST_CNT != 8'hFF))
                LOCK_LOST_CNT <= LOCK_LOST_CNT + 8'd1;
        end
    end

    assign SEQ_STATE = state;
endmodule

// File: tb/tb_init_reset_sequencer.sv
// Bench for init_reset_sequencer: three parameterisations share one stimulus stream and are
// checked every cycle against a run-length model, plus hand-computed edge expectations.

module tb_init_reset_sequencer;
    logic       CLK = 1'b0;
    logic       RESETN = 1'b0;
    logic       EXT_RST_N = 1'b1;
    logic       DEVICE_INIT_DONE = 1'b1;
    logic [3:0] CALIB_STATUS = 4'hF;
    logic       PLL_LOCK = 1'b1;

    logic [2:0]      frn;
    logic [2:0]      cd;
    logic [2:0][1:0] st;
    logic [2:0][7:0] llc;

    localparam int         LF_P[3]   = '{4, 4, 1};
    localparam int         HC_P[3]   = '{16, 16, 1};
    localparam logic [3:0] MASK_P[3] = '{4'hF, 4'hB, 4'hF};

    int n_chk = 0;
    int n_fail = 0;
    bit cmp_en = 1'b0;
    bit glitch_mon = 1'b0;
    int hold_seen = 0;

    init_reset_sequencer u0 (
        .CLK(CLK), .RESETN(RESETN), .EXT_RST_N(EXT_RST_N), .DEVICE_INIT_DONE(DEVICE_INIT_DONE),
        .CALIB_STATUS(CALIB_STATUS), .PLL_LOCK(PLL_LOCK), .FABRIC_RESET_N(frn[0]),
        .CALIB_DONE(cd[0]), .SEQ_STATE(st[0]), .LOCK_LOST_CNT(llc[0]));

    init_reset_sequencer #(.CALIB_MASK(4'b1011)) u1 (
        .CLK(CLK), .RESETN(RESETN), .EXT_RST_N(EXT_RST_N), .DEVICE_INIT_DONE(DEVICE_INIT_DONE),
        .CALIB_STATUS(CALIB_STATUS), .PLL_LOCK(PLL_LOCK), .FABRIC_RESET_N(frn[1]),
        .CALIB_DONE(cd[1]), .SEQ_STATE(st[1]), .LOCK_LOST_CNT(llc[1]));

    init_reset_sequencer #(.LOCK_FILTER(1), .HOLD_CYCLES(1)) u2 (
        .CLK(CLK), .RESETN(RESETN), .EXT_RST_N(EXT_RST_N), .DEVICE_INIT_DONE(DEVICE_INIT_DONE),
        .CALIB_STATUS(CALIB_STATUS), .PLL_LOCK(PLL_LOCK), .FABRIC_RESET_N(frn[2]),
        .CALIB_DONE(cd[2]), .SEQ_STATE(st[2]), .LOCK_LOST_CNT(llc[2]));

    initial forever #5 CLK = ~CLK;

    // Model: the FSM sees inputs sampled two edges earlier. State follows from run lengths:
    // g = consecutive "good" edges, q = consecutive good-and-locked edges, the first good
    // edge only leaves WAIT_INIT, then LF locked edges reach HOLD and LF+HC reach RUN.
    bit         e1, e2, i1, i2, l1, l2;
    logic [3:0] c1, c2;
    int         m_g[3], m_q[3], m_st[3], m_llc[3];
    bit         m_cd[3];

    always @(posedge CLK or negedge RESETN) begin
        if (!RESETN) begin
            e1 = 1'b1; e2 = 1'b1; i1 = 1'b0; i2 = 1'b0; l1 = 1'b0; l2 = 1'b0;
            c1 = 4'h0; c2 = 4'h0;
            for (int k = 0; k < 3; k++) begin
                m_g[k] = 0; m_q[k] = 0; m_st[k] = 0; m_llc[k] = 0; m_cd[k] = 1'b0;
            end
        end else begin
            for (int k = 0; k < 3; k++) begin
                bit cal, good;
                int qq, prev;
                cal  = ((c2 | ~MASK_P[k]) == 4'hF);
                good = e2 && i2 && cal;
                m_g[k] = good ? m_g[k] + 1 : 0;
                m_q[k] = (good && l2) ? m_q[k] + 1 : 0;
                qq   = (m_q[k] < m_g[k] - 1) ? m_q[k] : m_g[k] - 1;
                prev = m_st[k];
                if (!good)                       m_st[k] = 0;
                else if (qq < LF_P[k])           m_st[k] = 1;
                else if (qq < LF_P[k] + HC_P[k]) m_st[k] = 2;
                else                             m_st[k] = 3;
                if (prev == 3 && m_st[k] == 1 && m_llc[k] < 255) m_llc[k] = m_llc[k] + 1;
                m_cd[k] = cal;
            end
            e2 = e1; e1 = EXT_RST_N;
            i2 = i1; i1 = DEVICE_INIT_DONE;
            c2 = c1; c1 = CALIB_STATUS;
            l2 = l1; l1 = PLL_LOCK;
        end
    end

    always @(negedge CLK) begin
        if (cmp_en) begin
            for (int k = 0; k < 3; k++) begin
                logic [11:0] exp_v, act_v;
                exp_v = {m_st[k] == 3, m_cd[k], 2'(m_st[k]), 8'(m_llc[k])};
                act_v = {frn[k], cd[k], st[k], llc[k]};
                n_chk++;
                if (act_v !== exp_v) begin
                    n_fail++;
                    $display("FAIL cycle_cmp dut%0d t=%0t got frn=%b cd=%b st=%0d llc=%0d want frn=%b cd=%b st=%0d llc=%0d",
                             k, $time, act_v[11], act_v[10], act_v[9:8], act_v[7:0],
                             exp_v[11], exp_v[10], exp_v[9:8], exp_v[7:0]);
                end
            end
        end
        if (glitch_mon && st[0] == 2'd2) hold_seen++;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string nm, input int act, input int exp_v);
        n_chk++;
        if (act !== exp_v) begin
            n_fail++;
            $display("FAIL %s got %0d want %0d", nm, act, exp_v);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge CLK);
        #2;
    endtask

    // After this returns, the next rising edge is edge 1.
    task automatic do_reset();
        RESETN = 1'b0;
        tick(2);
        RESETN = 1'b1;
    endtask

    task automatic startup_checks();
        tick(2);
        chk("st_e2", st[0], 0);
        tick(1);
        chk("st_e3", st[0], 1);
        chk("cd_e3", cd[0], 1);
        chk("lf1_st_e3", st[2], 1);
        tick(1);
        chk("lf1_st_e4", st[2], 2);
        tick(1);
        chk("lf1_st_e5", st[2], 3);
        chk("lf1_frn_e5", frn[2], 1);
        tick(2);
        chk("st_e7", st[0], 2);
        chk("model_st_e7", m_st[0], 2);
        tick(15);
        chk("frn_e22", frn[0], 0);
        tick(1);
        chk("frn_e23", frn[0], 1);
        chk("st_e23", st[0], 3);
        chk("model_st_e23", m_st[0], 3);
    endtask

    initial begin
        cmp_en = 1'b1;
        tick(1);
        chk("reset_frn", frn[0], 0);
        chk("reset_st", st[0], 0);
        chk("reset_llc", llc[0], 0);

        // Power-up with everything ready.
        do_reset();
        startup_checks();

        // Asynchronous reset in the middle of HOLD, then identical startup.
        do_reset();
        tick(12);
        chk("hold_before_rst", st[0], 2);
        RESETN = 1'b0;
        #1;
        chk("async_rst_st", st[0], 0);
        chk("async_rst_cd", cd[0], 0);
        chk("async_rst_frn", frn[0], 0);
        do_reset();
        startup_checks();

        // Bank 2 not calibrated: only the instance that masks it out proceeds.
        CALIB_STATUS = 4'b1011;
        do_reset();
        tick(22);
        chk("mask_frn_e22", frn[1], 0);
        tick(1);
        chk("mask_frn_e23", frn[1], 1);
        chk("nomask_st_e23", st[0], 0);
        tick(20);
        chk("nomask_st_late", st[0], 0);
        chk("nomask_frn_late", frn[0], 0);
        chk("nomask_cd_late", cd[0], 0);
        chk("mask_cd_late", cd[1], 1);
        CALIB_STATUS = 4'hF;

        // Lock glitching 3 high / 1 low never qualifies a 4-sample filter.
        PLL_LOCK = 1'b1;
        do_reset();
        glitch_mon = 1'b1;
        repeat (25) begin
            tick(3);
            PLL_LOCK = 1'b0;
            tick(1);
            PLL_LOCK = 1'b1;
        end
        glitch_mon = 1'b0;
        chk("glitch_hold_seen", hold_seen, 0);
        chk("glitch_frn", frn[0], 0);
        chk("glitch_llc", llc[0], 0);

        // Lock loss together with external reset: external reset wins, no lock-loss count.
        do_reset();
        tick(30);
        PLL_LOCK = 1'b0;
        tick(5);
        PLL_LOCK = 1'b1;
        tick(25);
        chk("ext_pre_st", st[0], 3);
        chk("ext_pre_llc", llc[0], 1);
        EXT_RST_N = 1'b0;
        PLL_LOCK  = 1'b0;
        tick(3);
        chk("ext_st", st[0], 0);
        chk("ext_llc", llc[0], 1);
        chk("ext_frn", frn[0], 0);
        tick(5);
        EXT_RST_N = 1'b1;
        PLL_LOCK  = 1'b1;
        tick(2);
        chk("ext_rel_st_e2", st[0], 0);
        tick(1);
        chk("ext_rel_st_e3", st[0], 1);
        tick(20);
        chk("ext_rel_frn_e23", frn[0], 1);
        chk("ext_rel_llc", llc[0], 1);

        // Repeated lock loss from RUN: counter climbs and saturates.
        do_reset();
        tick(25);
        for (int i = 0; i < 300; i++) begin
            PLL_LOCK = 1'b0;
            tick(2);
            chk("drop_frn_e2", frn[0], 1);
            tick(1);
            chk("drop_frn_e3", frn[0], 0);
            chk("drop_llc", llc[0], (i + 1 > 255) ? 255 : i + 1);
            tick(7);
            PLL_LOCK = 1'b1;
            tick(21);
            chk("rise_frn_e21", frn[0], 0);
            tick(1);
            chk("rise_frn_e22", frn[0], 1);
        end
        chk("sat_llc", llc[0], 255);
        chk("model_sat_llc", m_llc[0], 255);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
